// File: rtl/rca_addsub_seq.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : rca_addsub_seq
// Description : Sequential ripple-carry adder/subtractor. Resolves CHUNK bits
//               per clock, so a WIDTH-bit operation takes WIDTH/CHUNK cycles.
//               Handshaked on both sides; a result held under backpressure
//               can be retired on the same edge that accepts the next job.
// Revision    : 1.0 - initial release
// ============================================================================
module rca_addsub_seq #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf,
   output logic             zero
);

   localparam int N  = WIDTH / CHUNK;
   localparam int KW = (N > 1) ? $clog2(N) : 1;
   localparam logic [KW-1:0] c_K_LAST = KW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_next;

   // Operands are consumed from the LSB end; both shift right each RUN edge.
   logic [WIDTH-1:0]       r_a;
   logic [WIDTH-1:0]       r_b;
   logic                   r_carry;
   logic [KW-1:0]          r_k;
   // Partial sum fills from the top so it is aligned after the last chunk.
   logic [WIDTH-1:0]       r_acc;
   logic [WIDTH-1:0]       r_sum;
   logic                   r_c_out;
   logic                   r_ovf;
   logic                   r_zero;

   logic                   w_accept;
   logic                   w_last;
   logic [CHUNK-1:0]       w_chunk_sum;
   logic                   w_c;
   logic                   w_c_msb_in;
   logic [WIDTH+CHUNK-1:0] w_cat;
   logic [WIDTH-1:0]       w_acc_next;

   assign in_ready   = (r_state == IDLE) || ((r_state == DONE) && out_ready);
   assign w_accept   = in_valid && in_ready;
   assign w_last     = (r_state == RUN) && (r_k == c_K_LAST);
   assign out_valid  = (r_state == DONE);
   assign sum        = r_sum;
   assign c_out      = r_c_out;
   assign ovf        = r_ovf;
   assign zero       = r_zero;

   // Ripple one chunk; also keep the carry into the chunk's top bit, which on
   // the final chunk is the carry into the MSB needed for signed overflow.
   always_comb begin
      w_c         = r_carry;
      w_c_msb_in  = r_carry;
      w_chunk_sum = '0;
      for (int i = 0; i < CHUNK; i++) begin
         w_c_msb_in     = w_c;
         w_chunk_sum[i] = r_a[i] ^ r_b[i] ^ w_c;
         w_c            = (r_a[i] & r_b[i]) | (w_c & (r_a[i] ^ r_b[i]));
      end
   end

   assign w_cat      = {w_chunk_sum, r_acc};
   assign w_acc_next = w_cat[WIDTH+CHUNK-1:CHUNK];

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   // Next-state: DONE with a waiting job goes straight back to RUN.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_next = RUN;
         RUN:     if (w_last)   w_state_next = DONE;
         DONE: begin
            if (out_ready) w_state_next = in_valid ? RUN : IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Datapath: load on accept, ripple while running, publish on last chunk.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_carry <= 1'b0;
         r_k     <= '0;
         r_acc   <= '0;
         r_sum   <= '0;
         r_c_out <= 1'b0;
         r_ovf   <= 1'b0;
         r_zero  <= 1'b0;
      end else if (w_accept) begin
         // Subtract is a + ~b + ~borrow; inversion happens once at load.
         r_a     <= a;
         r_b     <= b ^ {WIDTH{op}};
         r_carry <= c_in ^ op;
         r_k     <= '0;
      end else if (r_state == RUN) begin
         r_a     <= r_a >> CHUNK;
         r_b     <= r_b >> CHUNK;
         r_carry <= w_c;
         r_acc   <= w_acc_next;
         r_k     <= r_k + 1'b1;
         if (w_last) begin
            r_sum   <= w_acc_next;
            r_c_out <= w_c;
            r_ovf   <= w_c ^ w_c_msb_in;
            r_zero  <= (w_acc_next == '0);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rca_addsub_seq.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : tb_rca_addsub_seq
// Description : Self-checking bench for rca_addsub_seq at CHUNK = 2, 1 and 8
//               against an integer-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rca_addsub_seq;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   logic       in_valid_v [3];
   logic       in_ready_v [3];
   logic [7:0] a_v        [3];
   logic [7:0] b_v        [3];
   logic       c_in_v     [3];
   logic       op_v       [3];
   logic       out_valid_v[3];
   logic       out_ready_v[3];
   logic [7:0] sum_v      [3];
   logic       c_out_v    [3];
   logic       ovf_v      [3];
   logic       zero_v     [3];

   int         n_lat[3] = '{4, 8, 1};
   logic [10:0] exp_v[3];

   int n_checks = 0;
   int n_pass   = 0;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_dut
         localparam int CH = (gi == 0) ? 2 : ((gi == 1) ? 1 : 8);
         rca_addsub_seq #(.WIDTH(8), .CHUNK(CH)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid_v[gi]),
            .in_ready  (in_ready_v[gi]),
            .a         (a_v[gi]),
            .b         (b_v[gi]),
            .c_in      (c_in_v[gi]),
            .op        (op_v[gi]),
            .out_valid (out_valid_v[gi]),
            .out_ready (out_ready_v[gi]),
            .sum       (sum_v[gi]),
            .c_out     (c_out_v[gi]),
            .ovf       (ovf_v[gi]),
            .zero      (zero_v[gi])
         );
      end
   endgenerate

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Returns {c_out, ovf, zero, sum[7:0]} from plain integer arithmetic.
   function automatic logic [10:0] model(input logic [7:0] x, input logic [7:0] y,
                                         input logic o, input logic ci);
      int         r;
      int         rs;
      logic [7:0] s;
      logic       co;
      logic       ov;
      if (!o) begin
         r  = int'(x) + int'(y) + int'(ci);
         rs = int'($signed(x)) + int'($signed(y)) + int'(ci);
         co = (r > 255);
      end else begin
         r  = int'(x) - int'(y) - int'(ci);
         rs = int'($signed(x)) - int'($signed(y)) - int'(ci);
         co = (r >= 0);
      end
      s  = r[7:0];
      ov = (rs > 127) || (rs < -128);
      return {co, ov, (s == 8'd0), s};
   endfunction

   // Present a job to DUT d and return just after the accepting edge.
   task automatic start_op(input int d, input logic [7:0] x, input logic [7:0] y,
                           input logic o, input logic ci);
      int cnt;
      a_v[d]        = x;
      b_v[d]        = y;
      op_v[d]       = o;
      c_in_v[d]     = ci;
      in_valid_v[d] = 1'b1;
      exp_v[d]      = model(x, y, o, ci);
      cnt = 0;
      while (!in_ready_v[d] && cnt < 50) begin
         @(posedge clk); #1;
         cnt++;
      end
      check($sformatf("d%0d_in_ready", d), {31'd0, in_ready_v[d]}, 32'd1);
      @(posedge clk); #1;
      in_valid_v[d] = 1'b0;
      // Scramble inputs while running; they must be ignored.
      a_v[d]    = 8'($urandom);
      b_v[d]    = 8'($urandom);
      op_v[d]   = 1'($urandom);
      c_in_v[d] = 1'($urandom);
   endtask

   // Wait for the result with a bounded edge count, then check latency and values.
   task automatic finish_op(input int d, input string tag);
      int edges;
      edges = 0;
      while (!out_valid_v[d] && edges < 20) begin
         @(posedge clk); #1;
         edges++;
      end
      check($sformatf("d%0d_%s_latency", d, tag), edges, n_lat[d]);
      check($sformatf("d%0d_%s_sum", d, tag),   {24'd0, sum_v[d]},   {24'd0, exp_v[d][7:0]});
      check($sformatf("d%0d_%s_c_out", d, tag), {31'd0, c_out_v[d]}, {31'd0, exp_v[d][10]});
      check($sformatf("d%0d_%s_ovf", d, tag),   {31'd0, ovf_v[d]},   {31'd0, exp_v[d][9]});
      check($sformatf("d%0d_%s_zero", d, tag),  {31'd0, zero_v[d]},  {31'd0, exp_v[d][8]});
   endtask

   task automatic run_op(input int d, input logic [7:0] x, input logic [7:0] y,
                         input logic o, input logic ci, input string tag);
      start_op(d, x, y, o, ci);
      finish_op(d, tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      for (int d = 0; d < 3; d++) begin
         in_valid_v[d]  = 1'b0;
         a_v[d]         = 8'd0;
         b_v[d]         = 8'd0;
         c_in_v[d]      = 1'b0;
         op_v[d]        = 1'b0;
         out_ready_v[d] = 1'b1;
      end
      #2;
      check("rst_out_valid", {31'd0, out_valid_v[0]}, 32'd0);
      check("rst_sum",       {24'd0, sum_v[0]},       32'd0);
      check("rst_c_out",     {31'd0, c_out_v[0]},     32'd0);
      check("rst_ovf",       {31'd0, ovf_v[0]},       32'd0);
      check("rst_zero",      {31'd0, zero_v[0]},      32'd0);
      check("rst_in_ready",  {31'd0, in_ready_v[0]},  32'd1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Directed vectors on every chunking.
      for (int d = 0; d < 3; d++) begin
         run_op(d, 8'h05, 8'h03, 1'b1, 1'b0, "sub");
         run_op(d, 8'h03, 8'h05, 1'b1, 1'b0, "borrow");
         run_op(d, 8'h80, 8'h01, 1'b1, 1'b0, "sub_ovf");
         run_op(d, 8'h7F, 8'h01, 1'b0, 1'b0, "add_ovf");
         run_op(d, 8'hFF, 8'h00, 1'b0, 1'b1, "add_wrap");
      end

      // Backpressure: result held five cycles, then back-to-back accept.
      out_ready_v[0] = 1'b0;
      run_op(0, 8'h5A, 8'h33, 1'b0, 1'b0, "bp1");
      repeat (5) begin
         @(posedge clk); #1;
         check("bp_hold_valid", {31'd0, out_valid_v[0]}, 32'd1);
         check("bp_hold_sum",   {24'd0, sum_v[0]},       {24'd0, exp_v[0][7:0]});
         check("bp_in_ready",   {31'd0, in_ready_v[0]},  32'd0);
      end
      a_v[0] = 8'h11; b_v[0] = 8'h22; op_v[0] = 1'b0; c_in_v[0] = 1'b0;
      exp_v[0] = model(8'h11, 8'h22, 1'b0, 1'b0);
      in_valid_v[0]  = 1'b1;
      out_ready_v[0] = 1'b1;
      #1;
      check("bp_release_ready", {31'd0, in_ready_v[0]}, 32'd1);
      @(posedge clk); #1;
      in_valid_v[0] = 1'b0;
      check("bp_b2b_running", {31'd0, out_valid_v[0]}, 32'd0);
      finish_op(0, "bp2");

      // Asynchronous reset two edges into a run.
      start_op(0, 8'h44, 8'h10, 1'b0, 1'b0);
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1;
      #1;
      check("arst_out_valid", {31'd0, out_valid_v[0]}, 32'd0);
      check("arst_sum",       {24'd0, sum_v[0]},       32'd0);
      check("arst_in_ready",  {31'd0, in_ready_v[0]},  32'd1);
      a_v[0] = 8'h10; b_v[0] = 8'h20; op_v[0] = 1'b0; c_in_v[0] = 1'b0;
      in_valid_v[0] = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
         check("arst_no_accept", {31'd0, out_valid_v[0]}, 32'd0);
      end
      rst = 1'b0;
      run_op(0, 8'h10, 8'h20, 1'b0, 1'b0, "post_rst");

      // Random operations against the model.
      for (int d = 0; d < 3; d++) begin
         for (int i = 0; i < 20; i++) begin
            run_op(d, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), "rand");
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
